// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared state encodings, colour codes and helpers for the Genius round sequencer
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P_FETCH,
    ST_P_ON,
    ST_P_OFF,
    ST_U_WAIT,
    ST_U_EVAL
  } state_t;

  localparam logic [1:0] COL_GREEN  = 2'd0;
  localparam logic [1:0] COL_RED    = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_BLUE   = 2'd3;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/genius_tick_timer.sv
// rtl/genius_tick_timer.sv - loadable count-down tick timer with a zero flag
module genius_tick_timer #(
  parameter int CW = 24
) (
  input  logic          clock,
  input  logic          reset_i,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          enable,
  output logic          done
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/genius_round_sequencer.sv
// rtl/genius_round_sequencer.sv - plays one Genius round on the LEDs and checks the player's presses
module genius_round_sequencer
  import genius_pkg::*;
#(
  parameter int AW        = 4,
  parameter int CW        = 24,
  parameter int ON_TICKS  = 12500000,
  parameter int OFF_TICKS = 5000000,
  parameter int TO_TICKS  = 250000000
) (
  input  logic          clock,
  input  logic          reset_i,
  input  logic          play_start_i,
  input  logic          user_start_i,
  input  logic [AW-1:0] round_i,
  output logic [AW-1:0] seq_addr_o,
  input  logic [1:0]    seq_data_i,
  input  logic [3:0]    btn_i,
  output logic [3:0]    led_o,
  output logic          busy_o,
  output logic          end_fpga_o,
  output logic          end_user_o,
  output logic          end_time_o,
  output logic          match_o
);

  // Timer is widened beyond CW whenever a tick count would not fit in it.
  localparam int TW = max_int(CW, max_int($clog2(TO_TICKS),
                              max_int($clog2(ON_TICKS), $clog2(OFF_TICKS))));

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] len_q, len_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    btn_q, btn_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          end_fpga_q, end_fpga_d;
  logic          end_user_q, end_user_d;
  logic          end_time_q, end_time_d;
  logic          match_q, match_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_enable;
  logic          tmr_done;

  genius_tick_timer #(
    .CW(TW)
  ) u_timer (
    .clock     (clock),
    .reset_i   (reset_i),
    .load      (tmr_load),
    .load_value(tmr_value),
    .enable    (tmr_enable),
    .done      (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    col_d      = col_q;
    btn_d      = btn_q;
    led_d      = 4'b0000;
    end_fpga_d = 1'b0;
    end_user_d = 1'b0;
    end_time_d = 1'b0;
    match_d    = match_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_enable = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (play_start_i) begin
          state_d = ST_P_FETCH;
          idx_d   = '0;
          len_d   = round_i;
        end else if (user_start_i) begin
          state_d   = ST_U_WAIT;
          idx_d     = '0;
          len_d     = round_i;
          match_d   = 1'b0;
          tmr_load  = 1'b1;
          tmr_value = TW'(TO_TICKS - 1);
        end
      end

      ST_P_FETCH: begin
        col_d     = seq_data_i;
        led_d     = onehot(seq_data_i);
        state_d   = ST_P_ON;
        tmr_load  = 1'b1;
        tmr_value = TW'(ON_TICKS - 1);
      end

      ST_P_ON: begin
        if (tmr_done) begin
          state_d   = ST_P_OFF;
          tmr_load  = 1'b1;
          tmr_value = TW'(OFF_TICKS - 1);
        end else begin
          led_d      = onehot(col_q);
          tmr_enable = 1'b1;
        end
      end

      ST_P_OFF: begin
        if (tmr_done) begin
          if (idx_q == len_q) begin
            state_d    = ST_IDLE;
            end_fpga_d = 1'b1;
          end else begin
            state_d = ST_P_FETCH;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          tmr_enable = 1'b1;
        end
      end

      ST_U_WAIT: begin
        // A press in the final timeout cycle still wins over the timeout.
        if (btn_i != 4'b0000) begin
          state_d = ST_U_EVAL;
          btn_d   = btn_i;
          led_d   = btn_i;
        end else if (tmr_done) begin
          state_d    = ST_IDLE;
          end_time_d = 1'b1;
          match_d    = 1'b0;
        end else begin
          tmr_enable = 1'b1;
        end
      end

      ST_U_EVAL: begin
        if (btn_q != onehot(seq_data_i)) begin
          state_d    = ST_IDLE;
          end_user_d = 1'b1;
          match_d    = 1'b0;
        end else if (idx_q == len_q) begin
          state_d    = ST_IDLE;
          end_user_d = 1'b1;
          match_d    = 1'b1;
        end else begin
          state_d   = ST_U_WAIT;
          idx_d     = idx_q + 1'b1;
          tmr_load  = 1'b1;
          tmr_value = TW'(TO_TICKS - 1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      col_q      <= '0;
      btn_q      <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      end_fpga_q <= 1'b0;
      end_user_q <= 1'b0;
      end_time_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      col_q      <= col_d;
      btn_q      <= btn_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      end_fpga_q <= end_fpga_d;
      end_user_q <= end_user_d;
      end_time_q <= end_time_d;
      match_q    <= match_d;
    end
  end

  assign seq_addr_o = idx_q;
  assign led_o      = led_q;
  assign busy_o     = busy_q;
  assign end_fpga_o = end_fpga_q;
  assign end_user_o = end_user_q;
  assign end_time_o = end_time_q;
  assign match_o    = match_q;

endmodule

// File: tb/tb_genius_round_sequencer.sv
// tb/tb_genius_round_sequencer.sv - randomized trace-model bench for genius_round_sequencer
module tb_genius_round_sequencer;

  localparam int AW  = 4;
  localparam int CW  = 24;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int TO  = 10;

  logic          clock = 1'b0;
  logic          reset_i;
  logic          play_start_i;
  logic          user_start_i;
  logic [AW-1:0] round_i;
  logic [AW-1:0] seq_addr_o;
  logic [1:0]    seq_data_i;
  logic [3:0]    btn_i;
  logic [3:0]    led_o;
  logic          busy_o;
  logic          end_fpga_o;
  logic          end_user_o;
  logic          end_time_o;
  logic          match_o;

  logic [1:0] mem [0:2**AW-1];

  assign seq_data_i = mem[seq_addr_o];

  always #5 clock = ~clock;

  genius_round_sequencer #(
    .AW(AW), .CW(CW), .ON_TICKS(ON), .OFF_TICKS(OFF), .TO_TICKS(TO)
  ) dut (
    .clock       (clock),
    .reset_i     (reset_i),
    .play_start_i(play_start_i),
    .user_start_i(user_start_i),
    .round_i     (round_i),
    .seq_addr_o  (seq_addr_o),
    .seq_data_i  (seq_data_i),
    .btn_i       (btn_i),
    .led_o       (led_o),
    .busy_o      (busy_o),
    .end_fpga_o  (end_fpga_o),
    .end_user_o  (end_user_o),
    .end_time_o  (end_time_o),
    .match_o     (match_o)
  );

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
    logic       ef;
    logic       eu;
    logic       et;
    logic       m;
  } out_t;

  typedef struct packed {
    logic          ps;
    logic          us;
    logic [AW-1:0] rnd;
    logic [3:0]    btn;
  } in_t;

  out_t       exp_q[$];
  in_t        in_q[$];
  int         plan_d[$];
  logic [3:0] plan_p[$];

  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  out_t cur_exp;
  int   cyc_idx;
  int   ef_seen, eu_seen, et_seen;
  bit   model_match = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc_idx, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic out_t mk_out(input logic [3:0] led, input logic busy, input logic ef,
                                  input logic eu, input logic et, input logic m);
    out_t o;
    o.led = led; o.busy = busy; o.ef = ef; o.eu = eu; o.et = et; o.m = m;
    return o;
  endfunction

  function automatic in_t mk_in(input logic ps, input logic us, input logic [AW-1:0] rnd,
                                input logic [3:0] btn);
    in_t x;
    x.ps = ps; x.us = us; x.rnd = rnd; x.btn = btn;
    return x;
  endfunction

  function automatic in_t busy_noise(input logic [3:0] btn);
    return mk_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 2**AW-1)), btn);
  endfunction

  function automatic in_t idle_noise();
    return mk_in(1'b0, 1'b0, '0, 4'($urandom_range(0, 15)));
  endfunction

  task automatic push(input in_t x, input out_t o);
    in_q.push_back(x);
    exp_q.push_back(o);
  endtask

  task automatic idle_tail();
    for (int i = 0; i < 2; i++) push(idle_noise(), mk_out(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_match));
  endtask

  // Play: per step one blank fetch cycle, ON lit cycles, OFF dark cycles; then one end_fpga cycle.
  task automatic gen_play(input logic [AW-1:0] rnd, input logic with_user);
    push(mk_in(1'b1, with_user, rnd, 4'($urandom_range(0, 15))),
         mk_out(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_match));
    for (int k = 0; k <= int'(rnd); k++) begin
      for (int c = 0; c < 1 + ON + OFF; c++) begin
        push(busy_noise(4'($urandom_range(0, 15))),
             mk_out((c >= 1 && c <= ON) ? oh(mem[k]) : 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_match));
      end
    end
    push(mk_in(1'b0, 1'b0, '0, 4'b0), mk_out(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, model_match));
    idle_tail();
  endtask

  // User: plan_d[k] is the wait-cycle index of press k (>= TO means no press), plan_p[k] its value.
  task automatic gen_user(input logic [AW-1:0] rnd);
    push(mk_in(1'b0, 1'b1, rnd, 4'b0), mk_out(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_match));
    model_match = 1'b0;
    for (int k = 0; k <= int'(rnd); k++) begin
      int d = plan_d[k];
      int w = (d < TO) ? d : TO - 1;
      for (int j = 0; j <= w; j++) begin
        push(busy_noise((j == d) ? plan_p[k] : 4'b0),
             mk_out(4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      if (d >= TO) begin
        push(mk_in(1'b0, 1'b0, '0, 4'b0), mk_out(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        break;
      end
      push(busy_noise(4'($urandom_range(0, 15))), mk_out(plan_p[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      if (plan_p[k] != oh(mem[k])) begin
        push(mk_in(1'b0, 1'b0, '0, 4'b0), mk_out(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        break;
      end
      if (k == int'(rnd)) begin
        model_match = 1'b1;
        push(mk_in(1'b0, 1'b0, '0, 4'b0), mk_out(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        break;
      end
    end
    idle_tail();
  endtask

  function automatic int model_first_ef();
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].ef) return i;
    return -1;
  endfunction

  task automatic run_trace();
    int n = exp_q.size();
    ef_seen = -1; eu_seen = -1; et_seen = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      play_start_i = in_q[i].ps;
      user_start_i = in_q[i].us;
      round_i      = in_q[i].rnd;
      btn_i        = in_q[i].btn;
      cur_exp      = exp_q[i];
      cyc_idx      = i;
      cmp_en       = 1'b1;
    end
    @(posedge clock); #1;
    cmp_en = 1'b0;
    play_start_i = 1'b0; user_start_i = 1'b0; round_i = '0; btn_i = 4'b0;
    exp_q.delete();
    in_q.delete();
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("led_o", 32'(led_o), 32'(cur_exp.led));
      chk("busy_o", 32'(busy_o), 32'(cur_exp.busy));
      chk("end_fpga_o", 32'(end_fpga_o), 32'(cur_exp.ef));
      chk("end_user_o", 32'(end_user_o), 32'(cur_exp.eu));
      chk("end_time_o", 32'(end_time_o), 32'(cur_exp.et));
      chk("match_o", 32'(match_o), 32'(cur_exp.m));
      if (end_fpga_o === 1'b1 && ef_seen < 0) ef_seen = cyc_idx;
      if (end_user_o === 1'b1 && eu_seen < 0) eu_seen = cyc_idx;
      if (end_time_o === 1'b1 && et_seen < 0) et_seen = cyc_idx;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; play_start_i = 1'b0; user_start_i = 1'b0; round_i = '0; btn_i = 4'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 2'($urandom_range(0, 3));
    cyc_idx = -1;
    #1;
    chk("rst_led", 32'(led_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_end_fpga", 32'(end_fpga_o), 32'd0);
    chk("rst_end_user", 32'(end_user_o), 32'd0);
    chk("rst_end_time", 32'(end_time_o), 32'd0);
    chk("rst_match", 32'(match_o), 32'd0);
    chk("rst_addr", 32'(seq_addr_o), 32'd0);
    @(negedge clock); @(negedge clock);
    reset_i = 1'b0;

    // Playback of {1,3,0}: end_fpga 18 edges after the start edge, i.e. trace index 19.
    mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd0;
    gen_play(AW'(2), 1'b0);
    chk("model_play_ef_idx", 32'(model_first_ef()), 32'd19);
    chk("model_play_led1", 32'(exp_q[1 + 1].led), 32'h2);
    chk("model_play_led2", 32'(exp_q[7 + 1].led), 32'h8);
    run_trace();
    chk("play_ef_idx", 32'(ef_seen), 32'd19);

    // Correct user round on {2,0}.
    mem[0] = 2'd2; mem[1] = 2'd0;
    plan_d = '{2, 0}; plan_p = '{4'b0100, 4'b0001};
    gen_user(AW'(1));
    run_trace();
    chk("user_ok_eu_idx", 32'(eu_seen), 32'd7);
    chk("user_ok_match_held", 32'(match_o), 32'd1);

    // Mismatch on the first press.
    mem[0] = 2'd2;
    plan_d = '{0}; plan_p = '{4'b0010};
    gen_user(AW'(2));
    run_trace();
    chk("user_bad_eu_idx", 32'(eu_seen), 32'd3);
    chk("user_bad_match", 32'(match_o), 32'd0);

    // Timeout with no press.
    plan_d = '{TO}; plan_p = '{4'b0000};
    gen_user(AW'(0));
    run_trace();
    chk("timeout_et_idx", 32'(et_seen), 32'd11);
    chk("timeout_busy", 32'(busy_o), 32'd0);

    // Press in the final wait cycle beats the timeout.
    mem[0] = 2'd3;
    plan_d = '{TO - 1}; plan_p = '{4'b1000};
    gen_user(AW'(0));
    run_trace();
    chk("late_press_no_et", 32'(et_seen), 32'hFFFF_FFFF);
    chk("late_press_eu_idx", 32'(eu_seen), 32'd12);

    // Play and user start together: playback wins.
    mem[0] = 2'd2; mem[1] = 2'd1;
    gen_play(AW'(1), 1'b1);
    run_trace();
    chk("collide_ef_idx", 32'(ef_seen), 32'd13);

    // Asynchronous reset in the middle of P_ON.
    mem[0] = 2'd3;
    @(posedge clock); #1; play_start_i = 1'b1; round_i = AW'(3);
    @(posedge clock); #1; play_start_i = 1'b0; round_i = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("pre_rst_led", 32'(led_o), 32'h8);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("mid_rst_led", 32'(led_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_match", 32'(match_o), 32'd0);
    @(negedge clock);
    chk("mid_rst_pulses", 32'({end_fpga_o, end_user_o, end_time_o}), 32'd0);
    @(negedge clock);
    reset_i = 1'b0;
    model_match = 1'b0;

    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] rnd;
      for (int i = 0; i < 2**AW; i++) mem[i] = 2'($urandom_range(0, 3));
      rnd = AW'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) begin
        gen_play(rnd, 1'($urandom_range(0, 1)));
      end else begin
        plan_d.delete();
        plan_p.delete();
        for (int k = 0; k <= int'(rnd); k++) begin
          int r = int'($urandom_range(0, 9));
          plan_d.push_back((r == 0) ? TO : int'($urandom_range(0, TO - 1)));
          plan_p.push_back((r == 1) ? 4'($urandom_range(1, 15)) : oh(mem[k]));
        end
        gen_user(rnd);
      end
      run_trace();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
